// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO: issues pops, absorbs the one-cycle
// read latency in a small skid buffer and presents a full-rate valid/ready stream.
module fifo_stream_reader #(
  parameter int WIDTH       = 8,
  parameter int BUF_DEPTH   = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               fifo_rd_en,
  input  logic [WIDTH-1:0]                   fifo_dout,
  input  logic                               fifo_empty,
  input  logic                               flush,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [WIDTH-1:0]                   m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count,
  output logic [COUNT_WIDTH-1:0]             beat_count
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [WIDTH-1:0]       mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [COUNT_WIDTH-1:0] beat_q, beat_d;
  logic                   inflight_q;
  logic                   flush_q;
  logic                   pop;
  logic                   capture;
  logic [CNT_W:0]         occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Reserve a slot for the word already requested so a capture can never overflow.
  assign occupancy  = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign fifo_rd_en = !rst && !flush && !fifo_empty &&
                      (occupancy < (CNT_W+1)'(BUF_DEPTH));

  assign capture    = inflight_q && !flush_q;
  assign m_valid    = (count_q != '0);
  assign m_data     = mem_q[head_q];
  assign pop        = m_valid && m_ready;
  assign buf_count  = count_q;
  assign beat_count = beat_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    beat_d  = beat_q;
    if (pop) begin
      head_d = ptr_inc(head_q);
      beat_d = beat_q + 1'b1;
    end
    if (capture) tail_d = ptr_inc(tail_q);
    case ({capture, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // The flush-cycle handshake still counts; everything else buffered is dropped.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      inflight_q <= fifo_rd_en;
      flush_q    <= flush;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem_q[tail_q] <= fifo_dout;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: models the registered-read FIFO and checks the
// delivered stream against the write order under directed and random traffic.
module tb_fifo_stream_reader;
  localparam int WIDTH       = 8;
  localparam int BUF_DEPTH   = 3;
  localparam int COUNT_WIDTH = 16;
  localparam int CW          = $clog2(BUF_DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   fifo_rd_en;
  logic [WIDTH-1:0]       fifo_dout = '0;
  logic                   fifo_empty;
  logic                   flush = 1'b0;
  logic                   m_valid;
  logic                   m_ready = 1'b0;
  logic [WIDTH-1:0]       m_data;
  logic [CW-1:0]          buf_count;
  logic [COUNT_WIDTH-1:0] beat_count;

  logic                   fifo_wr = 1'b0;
  logic [WIDTH-1:0]       fifo_wdata = '0;
  logic [WIDTH-1:0]       fifo_mem[$];
  logic [WIDTH-1:0]       wr_log[$];
  int                     fifo_n = 0;
  int                     popped_n = 0;
  logic                   rst_seen = 1'b0;

  int                     checks = 0;
  int                     failures = 0;
  int                     exp_idx = 0;
  logic [COUNT_WIDTH-1:0] exp_beats = '0;

  fifo_stream_reader #(
    .WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .buf_count(buf_count), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  // Synchronous FIFO: registered read data, registered empty, cleared when rst rises.
  assign fifo_empty = (fifo_n == 0);
  always @(posedge clk) begin
    rst_seen <= rst;
    if (rst && !rst_seen) begin
      fifo_mem.delete();
      wr_log.delete();
      popped_n = 0;
    end
    if (fifo_rd_en && fifo_mem.size() != 0) begin
      fifo_dout <= fifo_mem.pop_front();
      popped_n++;
    end
    if (fifo_wr) begin
      fifo_mem.push_back(fifo_wdata);
      wr_log.push_back(fifo_wdata);
    end
    fifo_n <= fifo_mem.size();
  end

  initial begin
    #600000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    logic [WIDTH-1:0] w [3];
    logic ev;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    rst = 1'b1; m_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fifo_wr = 1'b1; fifo_wdata = w[i];
      #1;
      checks++;
      if (m_valid !== 1'b0 || buf_count !== '0 || beat_count !== '0 || fifo_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_state valid=%b buf=%0d beats=%0d rd_en=%b required 0/0/0/0",
                 m_valid, buf_count, beat_count, fifo_rd_en);
      end
    end
    @(negedge clk);
    fifo_wr = 1'b0; rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      ev = (c >= 2 && c <= 4);
      checks++;
      if (m_valid !== ev) begin
        failures++;
        $display("FAIL reset_latency cycle=%0d m_valid=%b required=%b", c, m_valid, ev);
      end
      if (ev) begin
        checks++;
        if (m_data !== w[c-2]) begin
          failures++;
          $display("FAIL reset_data cycle=%0d got=%h required=%h", c, m_data, w[c-2]);
        end
      end
      checks++;
      if (fifo_rd_en !== (c < 3)) begin
        failures++;
        $display("FAIL reset_rd_en cycle=%0d got=%b required=%b", c, fifo_rd_en, (c < 3));
      end
    end
    checks++;
    if (beat_count !== 16'd3) begin
      failures++;
      $display("FAIL reset_beats got=%0d required=3", beat_count);
    end
    exp_idx = 3; exp_beats = 16'd3;
  endtask

  task automatic test_stream16();
    int wrote = 0;
    int got = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 60 && got < 16; c++) begin
      @(negedge clk);
      fifo_wr = (wrote < 16); fifo_wdata = 8'($urandom);
      if (fifo_wr) wrote++;
      #1;
      checks++;
      if (fifo_rd_en !== !fifo_empty) begin
        failures++;
        $display("FAIL stream_rd_en cycle=%0d got=%b required=%b", c, fifo_rd_en, !fifo_empty);
      end
      if (got > 0) begin
        checks++;
        if (m_valid !== 1'b1) begin
          failures++;
          $display("FAIL stream_bubble cycle=%0d m_valid=%b required=1", c, m_valid);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_idx >= wr_log.size()) begin
          failures++; $display("FAIL stream_extra got=%h required=none", m_data);
        end else if (m_data !== wr_log[exp_idx]) begin
          failures++; $display("FAIL stream_data[%0d] got=%h required=%h", exp_idx, m_data, wr_log[exp_idx]);
        end
        exp_idx++; exp_beats = exp_beats + 1'b1; got++;
      end
    end
    fifo_wr = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (got != 16) begin failures++; $display("FAIL stream_count got=%0d required=16", got); end
    checks++;
    if (beat_count !== exp_beats) begin
      failures++; $display("FAIL stream_beats got=%0d required=%0d", beat_count, exp_beats);
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] first;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fifo_wr = 1'b1; fifo_wdata = 8'($urandom);
    end
    first = wr_log[exp_idx];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      fifo_wr = 1'b0;
      #1;
      checks++;
      if (buf_count !== CW'(BUF_DEPTH) || fifo_rd_en !== 1'b0 || m_valid !== 1'b1 || m_data !== first) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d buf=%0d rd_en=%b valid=%b data=%h required %0d/0/1/%h",
                 c, buf_count, fifo_rd_en, m_valid, m_data, BUF_DEPTH, first);
      end
    end
    for (int c = 0; c < 40 && exp_idx < wr_log.size(); c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== wr_log[exp_idx]) begin
          failures++; $display("FAIL stall_data[%0d] got=%h required=%h", exp_idx, m_data, wr_log[exp_idx]);
        end
        exp_idx++; exp_beats = exp_beats + 1'b1;
      end
    end
    @(negedge clk); #1;
    checks++;
    if (exp_idx != wr_log.size() || beat_count !== exp_beats) begin
      failures++;
      $display("FAIL stall_drain delivered=%0d beats=%0d required %0d/%0d",
               exp_idx, beat_count, wr_log.size(), exp_beats);
    end
  endtask

  task automatic test_flush();
    int base;
    int wi = 0;
    int got = 0;
    bit done = 0;
    bit after = 0;
    // Stalled: two words buffered and one in flight are all discarded.
    base = exp_idx;
    m_ready = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      fifo_wr = (wi < 6); fifo_wdata = 8'($urandom);
      if (fifo_wr) wi++;
      if (buf_count == 2) begin
        flush = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin
          failures++; $display("FAIL flush_rd_en got=%b required=0", fifo_rd_en);
        end
        exp_idx = base + BUF_DEPTH;
        done = 1;
      end
    end
    @(negedge clk);
    flush = 1'b0; fifo_wr = (wi < 6); fifo_wdata = 8'($urandom);
    if (fifo_wr) wi++;
    #1;
    checks++;
    if (!done || m_valid !== 1'b0 || buf_count !== '0) begin
      failures++;
      $display("FAIL flush_clear seen=%0d valid=%b buf=%0d required 1/0/0", done, m_valid, buf_count);
    end
    for (int c = 0; c < 40 && (wi < 6 || exp_idx < wr_log.size()); c++) begin
      @(negedge clk);
      m_ready = 1'b1; fifo_wr = (wi < 6); fifo_wdata = 8'($urandom);
      if (fifo_wr) wi++;
      #1;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== wr_log[exp_idx]) begin
          failures++; $display("FAIL flush_resume[%0d] got=%h required=%h", exp_idx, m_data, wr_log[exp_idx]);
        end
        exp_idx++; exp_beats = exp_beats + 1'b1;
      end
    end
    // Streaming: the flush-cycle handshake is delivered, the rest is lost.
    wi = 0; done = 0;
    for (int c = 0; c < 80 && (wi < 10 || exp_idx < wr_log.size()); c++) begin
      @(negedge clk);
      flush = (got == 6 && !done && m_valid);
      fifo_wr = (wi < 10); fifo_wdata = 8'($urandom);
      if (fifo_wr) wi++;
      #1;
      if (after) begin
        checks++;
        if (m_valid !== 1'b0 || buf_count !== '0) begin
          failures++; $display("FAIL flush2_clear valid=%b buf=%0d required 0/0", m_valid, buf_count);
        end
        after = 0;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_idx >= wr_log.size()) begin
          failures++; $display("FAIL flush2_extra got=%h required=none", m_data);
        end else if (m_data !== wr_log[exp_idx]) begin
          failures++; $display("FAIL flush2_data[%0d] got=%h required=%h", exp_idx, m_data, wr_log[exp_idx]);
        end
        exp_idx++; exp_beats = exp_beats + 1'b1; got++;
      end
      if (flush) begin
        exp_idx = popped_n; done = 1; after = 1;
      end
    end
    flush = 1'b0; fifo_wr = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (!done || beat_count !== exp_beats) begin
      failures++; $display("FAIL flush_beats seen=%0d got=%0d required=%0d", done, beat_count, exp_beats);
    end
  endtask

  task automatic test_random();
    int wrote = 0;
    int got = 0;
    logic [COUNT_WIDTH-1:0] start;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [WIDTH-1:0] pd = '0;
    logic rd_a;
    start = exp_beats;
    for (int c = 0; c < 12000 && got < 1000; c++) begin
      @(negedge clk);
      fifo_wr = (wrote < 1000) && ($urandom_range(0, 1) == 1);
      fifo_wdata = 8'($urandom);
      if (fifo_wr) wrote++;
      m_ready = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (fifo_rd_en && fifo_empty) begin
        failures++; $display("FAIL rand_rd_empty cycle=%0d rd_en=1 required=0", c);
      end
      checks++;
      if (buf_count > BUF_DEPTH || m_valid !== (buf_count != 0)) begin
        failures++; $display("FAIL rand_occupancy cycle=%0d buf=%0d valid=%b", c, buf_count, m_valid);
      end
      if (pv && !pr) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== pd) begin
          failures++; $display("FAIL rand_stall_hold cycle=%0d valid=%b data=%h required 1/%h", c, m_valid, m_data, pd);
        end
      end
      rd_a = fifo_rd_en;
      m_ready = !m_ready;
      #1;
      checks++;
      if (fifo_rd_en !== rd_a) begin
        failures++; $display("FAIL rand_ready_path cycle=%0d rd_en=%b required=%b", c, fifo_rd_en, rd_a);
      end
      m_ready = !m_ready;
      #1;
      pv = m_valid; pr = m_ready; pd = m_data;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_idx >= wr_log.size()) begin
          failures++; $display("FAIL rand_extra got=%h required=none", m_data);
        end else if (m_data !== wr_log[exp_idx]) begin
          failures++; $display("FAIL rand_data[%0d] got=%h required=%h", exp_idx, m_data, wr_log[exp_idx]);
        end
        exp_idx++; exp_beats = exp_beats + 1'b1; got++;
      end
    end
    fifo_wr = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (got != 1000) begin failures++; $display("FAIL rand_count got=%0d required=1000", got); end
    checks++;
    if (beat_count !== start + COUNT_WIDTH'(1000)) begin
      failures++; $display("FAIL rand_beats got=%0d required=%0d", beat_count, start + COUNT_WIDTH'(1000));
    end
  endtask

  task automatic test_reset_mid();
    int wrote = 0;
    int got = 0;
    bit done = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (got == 5) begin
        rst = 1'b1; fifo_wr = 1'b0;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin
          failures++; $display("FAIL rstmid_rd_en got=%b required=0", fifo_rd_en);
        end
        done = 1;
      end else begin
        fifo_wr = (wrote < 12); fifo_wdata = 8'($urandom);
        if (fifo_wr) wrote++;
        #1;
        if (m_valid && m_ready) got++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (!done || m_valid !== 1'b0 || beat_count !== '0 || buf_count !== '0) begin
      failures++;
      $display("FAIL rstmid_clear seen=%0d valid=%b beats=%0d buf=%0d required 1/0/0/0",
               done, m_valid, beat_count, buf_count);
    end
    exp_idx = 0; exp_beats = '0; wrote = 0;
    for (int c = 0; c < 30 && (wrote < 4 || exp_idx < wr_log.size()); c++) begin
      @(negedge clk);
      fifo_wr = (wrote < 4); fifo_wdata = 8'($urandom);
      if (fifo_wr) wrote++;
      #1;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_idx >= wr_log.size()) begin
          failures++; $display("FAIL rstmid_extra got=%h required=none", m_data);
        end else if (m_data !== wr_log[exp_idx]) begin
          failures++; $display("FAIL rstmid_data[%0d] got=%h required=%h", exp_idx, m_data, wr_log[exp_idx]);
        end
        exp_idx++; exp_beats = exp_beats + 1'b1;
      end
    end
    fifo_wr = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (beat_count !== 16'd4 || exp_idx != 4) begin
      failures++; $display("FAIL rstmid_beats got=%0d delivered=%0d required 4/4", beat_count, exp_idx);
    end
  endtask

  initial begin
    test_reset();
    test_stream16();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
